// File: rtl/video_timing_pkg.sv
// Shared types and constants for the video timing meter.
// Reference totals describe common CEA formats.
package video_timing_pkg;

  localparam int DEF_CNT_W = 12;

  typedef enum logic [1:0] {
    S_WAIT,
    S_FIRST,
    S_RUN
  } state_t;

  localparam int H_TOTAL_1080 = 2200;
  localparam int V_TOTAL_1080 = 1125;
  localparam int H_TOTAL_720  = 1650;
  localparam int V_TOTAL_720  = 750;
  localparam int H_TOTAL_480  = 800;
  localparam int V_TOTAL_480  = 525;

endpackage

// File: rtl/vtm_sync_norm.sv
// Sync input register, polarity latch and active-edge pulse.
// Edges are held off until a de rise has fixed the polarity.
module vtm_sync_norm (
  input  logic clk,
  input  logic rst,
  input  logic sync,
  input  logic de_rise,
  output logic pol,
  output logic act_edge
);

  logic sync_r;
  logic act;
  logic act_q;
  logic seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 1'b0;
      pol    <= 1'b1;
      act_q  <= 1'b0;
      seen   <= 1'b0;
    end else begin
      sync_r <= sync;
      act_q  <= act;
      if (de_rise) begin
        pol  <= ~sync_r;
        seen <= 1'b1;
      end
    end
  end

  assign act      = sync_r ~^ pol;
  assign act_edge = seen & act & ~act_q;

endmodule

// File: rtl/video_timing_meter.sv
// Line/frame geometry meter with sync polarity detect and lock.
// Observes hs/vs/de only; pixel data is never touched.
module video_timing_meter
  import video_timing_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hs,
  input  logic             vs,
  input  logic             de,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic             hs_pol,
  output logic             vs_pol,
  output logic             meas_valid,
  output logic             locked,
  output logic             frame_tick
);

  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [MW-1:0] LOCK_M = MW'(LOCK_FRAMES);
  localparam logic [MW-1:0] LOCK_P = MW'(LOCK_FRAMES - 1);

  logic de_r;
  logic de_q;
  logic de_rise;
  logic hs_e;
  logic vs_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      de_r <= 1'b0;
      de_q <= 1'b0;
    end else begin
      de_r <= de;
      de_q <= de_r;
    end
  end

  assign de_rise = de_r & ~de_q;

  vtm_sync_norm u_hs (
    .clk      (clk),
    .rst      (rst),
    .sync     (hs),
    .de_rise  (de_rise),
    .pol      (hs_pol),
    .act_edge (hs_e)
  );

  vtm_sync_norm u_vs (
    .clk      (clk),
    .rst      (rst),
    .sync     (vs),
    .de_rise  (de_rise),
    .pol      (vs_pol),
    .act_edge (vs_e)
  );

  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] de_cnt;
  logic [CNT_W-1:0] line_cnt;
  logic [CNT_W-1:0] act_cnt;
  logic [CNT_W-1:0] line_len;
  logic [CNT_W-1:0] act_len;
  logic [CNT_W-1:0] ht_n;
  logic [CNT_W-1:0] ha_n;
  logic [CNT_W-1:0] vt_n;
  logic [CNT_W-1:0] va_n;
  logic             line_act;
  logic             timeout;
  logic             same;
  logic [1:0]       pol_l;
  logic [MW-1:0]    match_cnt;
  state_t           state;

  // A line closed together with the frame still belongs to that frame.
  assign line_act = hs_e && (de_cnt != '0);
  assign ht_n = hs_e ? pix_cnt : line_len;
  assign ha_n = line_act ? de_cnt : act_len;
  assign vt_n = (hs_e && line_cnt != MAX) ? line_cnt + ONE : line_cnt;
  assign va_n = (line_act && act_cnt != MAX) ? act_cnt + ONE : act_cnt;
  assign timeout = (pix_cnt == MAX) || (line_cnt == MAX);

  assign same = (ht_n == h_total) && (ha_n == h_active) &&
                (vt_n == v_total) && (va_n == v_active) &&
                (pol_l == {hs_pol, vs_pol});

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt  <= '0;
      de_cnt   <= '0;
      line_cnt <= '0;
      act_cnt  <= '0;
      line_len <= '0;
      act_len  <= '0;
    end else begin
      if (hs_e) begin
        pix_cnt  <= ONE;
        de_cnt   <= de_r ? ONE : '0;
        line_len <= pix_cnt;
      end else begin
        if (pix_cnt != MAX) pix_cnt <= pix_cnt + ONE;
        if (de_r && de_cnt != MAX) de_cnt <= de_cnt + ONE;
      end
      if (line_act) act_len <= de_cnt;
      if (vs_e) begin
        line_cnt <= '0;
        act_cnt  <= '0;
      end else begin
        line_cnt <= vt_n;
        act_cnt  <= va_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_WAIT;
      h_total    <= '0;
      h_active   <= '0;
      v_total    <= '0;
      v_active   <= '0;
      pol_l      <= 2'b11;
      match_cnt  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (timeout) begin
        state      <= S_WAIT;
        match_cnt  <= '0;
        meas_valid <= 1'b0;
        locked     <= 1'b0;
      end else if (vs_e) begin
        unique case (state)
          S_WAIT: state <= S_FIRST;
          S_FIRST: begin
            meas_valid <= 1'b1;
            match_cnt  <= '0;
            state      <= S_RUN;
          end
          S_RUN: begin
            if (same) begin
              if (match_cnt != LOCK_M) match_cnt <= match_cnt + MW'(1);
              if (match_cnt >= LOCK_P) locked <= 1'b1;
            end else begin
              match_cnt <= '0;
              locked    <= 1'b0;
            end
          end
          default: state <= S_WAIT;
        endcase
        if (state != S_WAIT) begin
          h_total    <= ht_n;
          h_active   <= ha_n;
          v_total    <= vt_n;
          v_active   <= va_n;
          pol_l      <= {hs_pol, vs_pol};
          frame_tick <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_timing_meter.sv
// Directed bench for video_timing_meter using miniature video formats
// so each frame is a few hundred clocks.
module tb_video_timing_meter;
  import video_timing_pkg::*;

  typedef struct {
    int ha; int hf; int hw; int hb;
    int va; int vf; int vw; int vb;
    bit pos;
  } fmt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hs = 1'b0;
  logic vs = 1'b0;
  logic de = 1'b0;
  logic [11:0] h_total;
  logic [11:0] h_active;
  logic [11:0] v_total;
  logic [11:0] v_active;
  logic hs_pol;
  logic vs_pol;
  logic meas_valid;
  logic locked;
  logic frame_tick;

  always #5 clk = ~clk;

  video_timing_meter #(.CNT_W(12), .LOCK_FRAMES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .hs         (hs),
    .vs         (vs),
    .de         (de),
    .h_total    (h_total),
    .h_active   (h_active),
    .v_total    (v_total),
    .v_active   (v_active),
    .hs_pol     (hs_pol),
    .vs_pol     (vs_pol),
    .meas_valid (meas_valid),
    .locked     (locked),
    .frame_tick (frame_tick)
  );

  // A: 30x18 positive, B: 24x15 negative, C: 32x20 positive
  fmt_t fa = '{20, 2, 3, 5, 12, 1, 2, 3, 1'b1};
  fmt_t fb = '{16, 2, 4, 2, 10, 1, 2, 2, 1'b0};
  fmt_t fc = '{24, 2, 3, 3, 14, 1, 2, 3, 1'b1};

  fmt_t cur;
  fmt_t nxt;
  bit pend = 0;
  bit run = 0;
  bit kill_arm = 0;
  bit kill_now = 0;
  bit vs_prev = 0;
  int x = 0;
  int y = 0;
  int vs_edges = 0;
  int errors = 0;
  int checks = 0;

  initial begin : gen
    int ht, vt, hst, lo, hi, p;
    bit h_on, v_on;
    forever begin
      @(negedge clk);
      if (!run) begin
        hs = ~cur.pos;
        vs = ~cur.pos;
        de = 1'b0;
        vs_prev = 0;
      end else begin
        if (x == 0 && y == 0) begin
          if (pend) begin
            cur = nxt;
            pend = 0;
          end
          kill_now = kill_arm;
          kill_arm = 0;
        end
        ht = cur.ha + cur.hf + cur.hw + cur.hb;
        vt = cur.va + cur.vf + cur.vw + cur.vb;
        hst = cur.ha + cur.hf;
        p = y * ht + x;
        lo = (cur.va + cur.vf) * ht + hst;
        hi = lo + cur.vw * ht;
        h_on = (x >= hst) && (x < hst + cur.hw);
        v_on = (p >= lo) && (p < hi);
        de = (x < cur.ha) && (y < cur.va) && !(kill_now && y == 5);
        hs = cur.pos ? h_on : ~h_on;
        vs = cur.pos ? v_on : ~v_on;
        if (v_on && !vs_prev) vs_edges++;
        vs_prev = v_on;
        x++;
        if (x == ht) begin
          x = 0;
          y++;
          if (y == vt) y = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(string tag);
    int n;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (frame_tick === 1'b1) break;
    end
    checks++;
    assert (frame_tick === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed no frame_tick in %0d clks expected a tick", tag, n);
    end
  endtask

  task automatic geom(string tag, int ht, int ha, int vt, int va);
    chk({tag, "_h_total"}, int'(h_total), ht);
    chk({tag, "_h_active"}, int'(h_active), ha);
    chk({tag, "_v_total"}, int'(v_total), vt);
    chk({tag, "_v_active"}, int'(v_active), va);
  endtask

  task automatic reset_vals(string tag);
    geom(tag, 0, 0, 0, 0);
    chk({tag, "_pols"}, int'({hs_pol, vs_pol}), 3);
    chk({tag, "_valid"}, int'(meas_valid), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_tick"}, int'(frame_tick), 0);
  endtask

  initial begin : main
    int n;
    cur = fa;
    nxt = fa;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_vals("reset");
    rst = 1'b0;
    @(posedge clk);
    vs_edges = 0;
    x = 0;
    y = 0;
    run = 1;

    // positive sync, hs/vs coincident
    wait_tick("a_tick1");
    chk("a_tick1_vs_edges", vs_edges, 2);
    geom("a_tick1", 30, 20, 18, 12);
    chk("a_hs_pol", int'(hs_pol), 1);
    chk("a_vs_pol", int'(vs_pol), 1);
    chk("a_valid", int'(meas_valid), 1);
    chk("a_tick1_locked", int'(locked), 0);
    wait_tick("a_tick2");
    chk("a_tick2_locked", int'(locked), 0);
    wait_tick("a_tick3");
    chk("a_tick3_locked", int'(locked), 1);
    chk("a_tick3_vs_edges", vs_edges, 4);

    // one frame with de low for line 5
    @(posedge clk);
    kill_arm = 1;
    wait_tick("kill_tick");
    geom("kill", 30, 20, 18, 11);
    chk("kill_locked", int'(locked), 0);
    wait_tick("kill_tick2");
    chk("kill2_v_active", int'(v_active), 12);
    chk("kill2_locked", int'(locked), 0);
    wait_tick("kill_tick3");
    chk("kill3_locked", int'(locked), 0);
    wait_tick("kill_tick4");
    chk("kill4_locked", int'(locked), 1);

    // format switch while locked
    @(posedge clk);
    nxt = fc;
    pend = 1;
    wait_tick("sw_tick1");
    geom("sw_tick1", 32, 24, 20, 14);
    chk("sw_tick1_locked", int'(locked), 0);
    wait_tick("sw_tick2");
    chk("sw_tick2_locked", int'(locked), 0);
    wait_tick("sw_tick3");
    chk("sw_tick3_locked", int'(locked), 1);

    // hs stalls long enough to saturate the pixel counter
    @(posedge clk);
    run = 0;
    n = 0;
    while (n < 4500 && meas_valid === 1'b1) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid", int'(meas_valid), 0);
    chk("stall_locked", int'(locked), 0);
    chk("stall_state", int'(dut.state), int'(S_WAIT));
    chk("stall_hold_h_total", int'(h_total), 32);
    checks++;
    assert (n >= 4000 && n <= 4200) else begin
      errors++;
      $error("FAIL stall_delay: observed %0d clks expected 4000..4200", n);
    end
    @(posedge clk);
    vs_edges = 0;
    x = 0;
    y = 0;
    run = 1;
    wait_tick("resume_tick");
    chk("resume_vs_edges", vs_edges, 2);
    chk("resume_valid", int'(meas_valid), 1);
    geom("resume", 32, 24, 20, 14);

    // reset pulse mid-frame
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_vals("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    vs_edges = 0;
    wait_tick("midrst_tick");
    chk("midrst_vs_edges", vs_edges, 2);
    geom("midrst", 32, 24, 20, 14);

    // negative sync from a clean reset
    @(posedge clk);
    run = 0;
    rst = 1'b1;
    cur = fb;
    @(posedge clk);
    @(posedge clk);
    rst = 1'b0;
    x = 0;
    y = 0;
    vs_edges = 0;
    run = 1;
    wait_tick("b_tick1");
    chk("b_tick1_vs_edges", vs_edges, 2);
    geom("b_tick1", 24, 16, 15, 10);
    chk("b_hs_pol", int'(hs_pol), 0);
    chk("b_vs_pol", int'(vs_pol), 0);
    chk("b_tick1_locked", int'(locked), 0);
    wait_tick("b_tick2");
    chk("b_tick2_locked", int'(locked), 0);
    wait_tick("b_tick3");
    chk("b_tick3_locked", int'(locked), 1);
    chk("b_tick3_vs_edges", vs_edges, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
